// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes
// and the select codes driven into the datapath.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } statetype;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    typedef struct packed {
        logic       pcupdate;
        logic       branch;
        logic       adrsrc;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       retire;
        logic [1:0] resultsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
    } ctrl_t;

    function automatic logic [1:0] imm_src(input logic [6:0] op);
        case (op)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps the FSM's ALUOp plus instruction fields to an ALU operation code.
module alu_decoder
    import mc_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // op5 separates R-type sub from addi, whose imm[10] lands on funct7b5
                    3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the shared-memory/shared-ALU RV32I datapath; enables are
// masked combinationally by reset so nothing writes once reset falls.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter statetype RESET_STATE = S_FETCH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic       Retire,
    output logic       Illegal
);

    statetype state;
    ctrl_t    ctrl;
    logic     illegal_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RESET_STATE;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state <= S_MEMADR;
                        OP_R:         state <= S_EXECUTER;
                        OP_I:         state <= S_EXECUTEI;
                        OP_BEQ:       state <= S_BEQ;
                        OP_JAL:       state <= S_JAL;
                        default: begin
                            state     <= S_FETCH;
                            illegal_q <= 1'b1;
                        end
                    endcase
                end
                S_MEMADR:   state <= (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  state <= S_MEMWB;
                S_MEMWB:    state <= S_FETCH;
                S_MEMWRITE: state <= S_FETCH;
                S_EXECUTER: state <= S_ALUWB;
                S_EXECUTEI: state <= S_ALUWB;
                S_ALUWB:    state <= S_FETCH;
                S_BEQ:      state <= S_FETCH;
                S_JAL:      state <= S_ALUWB;
                default:    state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.irwrite   = 1'b1;
                ctrl.pcupdate  = 1'b1;
                ctrl.alusrca   = SRCA_PC;
                ctrl.alusrcb   = SRCB_FOUR;
                ctrl.aluop     = ALUOP_ADD;
                ctrl.resultsrc = RES_ALURESULT;
            end
            S_DECODE: begin
                ctrl.alusrca = SRCA_OLDPC;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alusrca = SRCA_RD1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMREAD: begin
                ctrl.resultsrc = RES_ALUOUT;
                ctrl.adrsrc    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.resultsrc = RES_DATA;
                ctrl.regwrite  = 1'b1;
                ctrl.retire    = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.resultsrc = RES_ALUOUT;
                ctrl.adrsrc    = 1'b1;
                ctrl.memwrite  = 1'b1;
                ctrl.retire    = 1'b1;
            end
            S_EXECUTER: begin
                ctrl.alusrca = SRCA_RD1;
                ctrl.alusrcb = SRCB_RD2;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ctrl.alusrca = SRCA_RD1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.resultsrc = RES_ALUOUT;
                ctrl.regwrite  = 1'b1;
                ctrl.retire    = 1'b1;
            end
            S_BEQ: begin
                ctrl.alusrca   = SRCA_RD1;
                ctrl.alusrcb   = SRCB_RD2;
                ctrl.aluop     = ALUOP_SUB;
                ctrl.resultsrc = RES_ALUOUT;
                ctrl.branch    = 1'b1;
                ctrl.retire    = 1'b1;
            end
            S_JAL: begin
                ctrl.alusrca   = SRCA_OLDPC;
                ctrl.alusrcb   = SRCB_FOUR;
                ctrl.aluop     = ALUOP_ADD;
                ctrl.resultsrc = RES_ALUOUT;
                ctrl.pcupdate  = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop      (ctrl.aluop),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .op5        (op[5]),
        .alucontrol (ALUControl)
    );

    // reset gates every write strobe so an aborted instruction leaves no side effects
    assign PCWrite   = reset & (ctrl.pcupdate | (ctrl.branch & Zero));
    assign IRWrite   = reset & ctrl.irwrite;
    assign MemWrite  = reset & ctrl.memwrite;
    assign RegWrite  = reset & ctrl.regwrite;
    assign Retire    = reset & ctrl.retire;
    assign AdrSrc    = ctrl.adrsrc;
    assign ResultSrc = ctrl.resultsrc;
    assign ALUSrcA   = ctrl.alusrca;
    assign ALUSrcB   = ctrl.alusrcb;
    assign ImmSrc    = imm_src(op);
    assign Illegal   = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed cycle-by-cycle checks of the multicycle controller outputs.
module tb_multicycle_controller;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] BAD = 7'b0000000;

    logic       clk, reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Retire, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
        .Retire(Retire), .Illegal(Illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pcw, adr, mw, irw, rs[1:0], sa[1:0], sb[1:0], alu[2:0], imm[1:0], rw, ret, ill}
    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        logic [17:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   ncmp = 0;
    int   nfail = 0;

    function automatic logic [17:0] actual();
        return {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ALUControl, ImmSrc, RegWrite, Retire, Illegal};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z,
                       input logic pcw, input logic adr, input logic mw, input logic irw,
                       input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
                       input logic [2:0] alu, input logic [1:0] imm,
                       input logic rw, input logic ret, input logic ill);
        vec_t v;
        v.op = o; v.f3 = f3; v.f7 = f7; v.z = z;
        v.exp = {pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw, ret, ill};
        tbl.push_back(v);
    endtask

    // FETCH and DECODE rows shared by every instruction
    task automatic fd(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z,
                      input logic [1:0] imm, input logic ill);
        add(o, f3, f7, z, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0, 0, ill);
        add(o, f3, f7, z, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 0, 0, ill);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b0; op = LW; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;

        // lw: 5 cycles
        fd(LW, 3'b010, 0, 0, 2'b00, 0);
        add(LW, 3'b010, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0, 0);
        add(LW, 3'b010, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0, 0);
        add(LW, 3'b010, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1, 1, 0);
        // sw: 4 cycles
        fd(SW, 3'b010, 0, 0, 2'b01, 0);
        add(SW, 3'b010, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0, 0, 0);
        add(SW, 3'b010, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 1, 0);
        // beq taken / not taken: 3 cycles
        fd(BEQ, 3'b000, 0, 1, 2'b10, 0);
        add(BEQ, 3'b000, 0, 1, 1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 0, 1, 0);
        fd(BEQ, 3'b000, 0, 0, 2'b10, 0);
        add(BEQ, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 0, 1, 0);
        // R sub
        fd(RT, 3'b000, 1, 0, 2'b00, 0);
        add(RT, 3'b000, 1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00, 0, 0, 0);
        add(RT, 3'b000, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1, 1, 0);
        // addi with funct7b5=1 still adds
        fd(IT, 3'b000, 1, 0, 2'b00, 0);
        add(IT, 3'b000, 1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0, 0);
        add(IT, 3'b000, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1, 1, 0);
        // slt, ori, and, unlisted funct3
        fd(RT, 3'b010, 0, 0, 2'b00, 0);
        add(RT, 3'b010, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b101, 2'b00, 0, 0, 0);
        add(RT, 3'b010, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1, 1, 0);
        fd(IT, 3'b110, 0, 0, 2'b00, 0);
        add(IT, 3'b110, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b011, 2'b00, 0, 0, 0);
        add(IT, 3'b110, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1, 1, 0);
        fd(RT, 3'b111, 1, 0, 2'b00, 0);
        add(RT, 3'b111, 1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b010, 2'b00, 0, 0, 0);
        add(RT, 3'b111, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1, 1, 0);
        fd(RT, 3'b001, 1, 0, 2'b00, 0);
        add(RT, 3'b001, 1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 2'b00, 0, 0, 0);
        add(RT, 3'b001, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1, 1, 0);
        // jal: 4 cycles
        fd(JAL, 3'b000, 0, 0, 2'b11, 0);
        add(JAL, 3'b000, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11, 0, 0, 0);
        add(JAL, 3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b11, 1, 1, 0);
        // illegal: 2 cycles, no retire, Illegal sticks through the next lw
        fd(BAD, 3'b000, 0, 0, 2'b00, 0);
        fd(LW, 3'b010, 0, 0, 2'b00, 1);
        add(LW, 3'b010, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0, 1);
        add(LW, 3'b010, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0, 1);
        add(LW, 3'b010, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1, 1, 1);

        // reset state: FETCH selects, enables masked
        #12;
        chk("reset_outputs", 32'(actual()),
            32'({1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0}));
        #10;
        reset = 1'b1;  // t = 22 ns

        for (int i = 0; i < tbl.size(); i++) begin
            op = tbl[i].op; funct3 = tbl[i].f3; funct7b5 = tbl[i].f7; Zero = tbl[i].z;
            #1;
            chk($sformatf("vec%0d", i), 32'(actual()), 32'(tbl[i].exp));
            step();
        end

        // reset clears sticky Illegal and masks enables
        #1;
        reset = 1'b0;
        #1;
        chk("rst_clears_illegal", 32'(Illegal), 32'd0);
        chk("rst_masks_irwrite", 32'(IRWrite), 32'd0);
        chk("rst_masks_pcwrite", 32'(PCWrite), 32'd0);
        step();

        // async reset in the middle of a store
        op = SW; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;
        reset = 1'b1;
        #1;
        chk("sw_fetch_irwrite", 32'(IRWrite), 32'd1);
        step();
        step();
        step();
        chk("sw_memwrite_before_abort", 32'(MemWrite), 32'd1);
        chk("sw_adrsrc_before_abort", 32'(AdrSrc), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_memwrite_dropped", 32'(MemWrite), 32'd0);
        chk("abort_retire_dropped", 32'(Retire), 32'd0);
        chk("abort_state_fetch", 32'({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}),
            32'({1'b0, 2'b00, 2'b10, 2'b10}));
        chk("abort_irwrite_masked", 32'(IRWrite), 32'd0);
        step();
        chk("held_reset_fetch", 32'({MemWrite, ALUSrcB}), 32'({1'b0, 2'b10}));
        reset = 1'b1;
        #1;
        chk("post_reset_irwrite", 32'(IRWrite), 32'd1);
        chk("post_reset_pcwrite", 32'(PCWrite), 32'd1);
        step();
        chk("post_reset_decode", 32'({ALUSrcA, ALUSrcB, IRWrite}), 32'({2'b01, 2'b01, 1'b0}));
        step();
        step();
        chk("post_reset_sw_completes", 32'({MemWrite, Retire, RegWrite}), 32'({1'b1, 1'b1, 1'b0}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control unit for the multicycle RV32I datapath (lw, sw, R-type, I-type ALU, beq, jal). It replaces single-cycle combinational decode, so the memory and ALU are shared across cycles.
- A Moore FSM sequences fetch, decode, execute, memory and writeback, and drives every select and enable of the datapath.
- It sits inside the core next to the datapath, under top. The existing testbench observation (MemWrite, DataAdr, WriteData) stays valid.

Parameters:
- RESET_STATE, S_FETCH, state entered on reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset.
- op  in  7  instr[6:0], valid while IR is held.
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- Zero  in  1  ALU zero flag.
- PCWrite  out  1  PC enable = PCUpdate | (Branch & Zero).
- AdrSrc  out  1  0=PC, 1=Result.
- MemWrite  out  1  data memory write.
- IRWrite  out  1  latch instruction and OldPC.
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult.
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=RD1.
- ALUSrcB  out  2  00=RD2, 01=ImmExt, 10=constant 4.
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J.
- RegWrite  out  1  register file write.
- Retire  out  1  one-cycle pulse on the last cycle of each legal instruction.
- Illegal  out  1  sticky; set on an unknown opcode in DECODE, cleared only by reset.

Behaviour:
- State register updates on posedge clk, async clear to S_FETCH when reset=0.
- While reset=0, all enable outputs are forced to 0: PCWrite, IRWrite, MemWrite, RegWrite and Retire. Illegal is 0.
- Every other output is a pure function of state.
- ImmSrc depends only on op: 0000011/0010011 give 00; 0100011 gives 01; 1100011 gives 10; 1101111 gives 11; anything else gives 00.
- Signals not listed for a state are 0 / 00.
- State outputs and transitions:
  - FETCH: AdrSrc=0, IRWrite, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate. Go to DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target). Next state by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1100011 → BEQ
    - 1101111 → JAL
    - other → FETCH, and set Illegal
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. lw → MEMREAD, sw → MEMWRITE.
  - MEMREAD: ResultSrc=00, AdrSrc=1. Go to MEMWB.
  - MEMWB: ResultSrc=01, RegWrite, Retire. Go to FETCH.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite, Retire. Go to FETCH.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Go to ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Go to ALUWB.
  - ALUWB: ResultSrc=00, RegWrite, Retire. Go to FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch, Retire. Go to FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate. Go to ALUWB.
- Latency in cycles: lw 5, sw 4, R 4, I 4, jal 4, beq 3, illegal 2 (no Retire).
- ALU decode:
  - ALUOp 00 → add; 01 → sub.
  - ALUOp 10, by funct3:
    - 000: sub if (op[5] & funct7b5), else add. addi ignores funct7b5.
    - 010: slt. 110: or. 111: and.
    - other funct3: add (deterministic, no X).
- PCWrite in BEQ equals Zero, sampled combinationally in that same cycle.
- Reset mid-instruction: state returns to FETCH immediately. No partial MemWrite/RegWrite may occur after reset falls.

Decomposition:
- Package mc_pkg holds:
  - statetype enum (S_FETCH … S_JAL, 4-bit)
  - opcode constants OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL
  - ALUControl, ImmSrc, ResultSrc and ALUSrc encodings
- One sub-module, alu_decoder (ALUOp, funct3, funct7b5, op5 → ALUControl). The FSM and instruction decoder stay in multicycle_controller.

Test Plan:
- Release reset at 22 ns, op=0000011 (lw). States FETCH, DECODE, MEMADR, MEMREAD, MEMWB across 5 cycles. IRWrite=1 and PCWrite=1 only in cycle 1; RegWrite=1 and ResultSrc=01 only in cycle 5; Retire once.
- op=0100011 (sw). MemWrite=1 exactly in cycle 4 with AdrSrc=1; then FETCH; RegWrite never 1.
- op=1100011, Zero=1 → PCWrite=1 in cycle 3. Repeat with Zero=0 → PCWrite=0 in cycle 3. Both retire after 3 cycles.
- op=0110011, funct3=000, funct7b5=1 → ALUControl=001 in EXECUTER. Same operands with op=0010011 → 000. funct3=010 → 101.
- op=0000000 → FETCH, DECODE, FETCH; Illegal=1 from the next edge and held; Retire never pulses. Reset=0 clears Illegal.
- Assert reset=0 asynchronously mid-MEMWRITE (before the clock edge). MemWrite drops immediately, state is FETCH, and the first post-reset cycle shows IRWrite=1.
